prio_encoder_rr: RTL
====================

Name: prio_encoder_rr

Overview:
- Parametrised N-to-log2(N) encoder with registered, handshaked output.
- Successor to the team's fixed 16-to-4 combinational encoder, with three additions:
  - true priority resolution when several inputs are set;
  - selectable fixed-priority or round-robin mode;
  - valid/ready output stage that holds a result under backpressure.
- Feeds arbitration and interrupt-vector paths that need one encoded winner per cycle.

Parameters:
- N, 16: number of request inputs; legal range N >= 2, not necessarily a power of two.
- W, $clog2(N): output index width; localparam, derived from N.
- MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  capture enable; 0 blocks new captures only.
- ip  input  N  request vector.
- op_ready  input  1  downstream accepts the output this cycle.
- op_valid  output  1  op/op_onehot/multi hold a valid result.
- op  output  W  encoded winner index.
- op_onehot  output  N  one-hot form of the winner.
- multi  output  1  more than one ip bit was set at capture.

Behaviour:
- Reset (rst=1 at a rising edge):
  - op_valid=0, op=0, op_onehot=0, multi=0.
  - Round-robin pointer ptr=N-1.
  - Reset takes effect mid-transfer too: a pending result is dropped and is not re-presented.
- Capture condition: cap = en & (|ip) & (~op_valid | op_ready).
- On cap, on the next edge:
  - op_valid=1.
  - op = winner index; op_onehot = 1<<winner.
  - multi = (popcount(ip) > 1).
- Latency and throughput: 1 cycle from ip sample to op_valid. With op_ready held at 1, one result per cycle.
- Output drain: if op_valid & op_ready & ~cap, then op_valid goes to 0 on the next edge. op and op_onehot keep their last value; their content is don't-care while op_valid=0.
- Backpressure: while op_valid & ~op_ready, op, op_onehot and multi are frozen. ip changes in this period are ignored; there is no queueing.
- en=0: no capture. A pending result still drains normally, never dropped.
- ip=0 with en=1: no capture. op_valid falls after the current result is accepted.
- Fixed mode (MODE=0): winner = highest set index. For one-hot ip this matches the legacy encoder; op = index of the set bit.
- Round-robin mode (MODE=1):
  - Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set bit wins.
  - On cap: ptr <= (winner==0) ? N-1 : winner-1.
  - ptr changes only on cap; backpressure and en=0 leave it unchanged.
  - Immediately after reset the behaviour is identical to fixed mode.
- Wrap-around: winner 0 sets ptr to N-1. The result must be correct for non-power-of-two N; ptr and op never exceed N-1.
- Simultaneous accept and capture: when op_valid & op_ready & cap, the new result replaces the old on the same edge and op_valid stays 1.
- All outputs are driven directly from flops.

Decomposition:
- Shared package (enc_pkg):
  - MODE_FIXED=0 and MODE_RR=1 constants.
  - clog2 helper function, used where the tool lacks $clog2.
- Sub-module prio_pick (combinational):
  - Inputs: N-bit request and ptr.
  - Outputs: winner index, any-set and multi.
  - Rotates the request by ptr, does a highest-set-bit search, then un-rotates.
  - Fixed mode ties ptr to N-1.
- The top level holds the output register, handshake logic and ptr register.

Test Plan:
- Fixed, N=16, ready=1, en=1, ip=16'h8001:
  - after 1 cycle, op_valid=1, op=15, op_onehot=16'h8000, multi=1;
  - with ip=16'h0004 next, op=2, multi=0.
- RR, N=16, ip=16'hFFFF held, ready=1: op sequence is 15, 14, ..., 0, 15, one per cycle.
- RR, N=16, ip=16'h0011, ready=1: grants alternate 4, 0, 4, 0.
- Backpressure:
  - Capture ip=16'h0100 (op=8), then ready=0 for 3 cycles while ip=16'h0002: op stays 8, op_valid=1, ptr unchanged.
  - Raise ready: the next cycle shows op=1.
- en=0 with ip=16'hFFFF: op_valid stays 0. With a result pending and en dropped, that result is still accepted once, then op_valid=0.
- Reset mid-stream in RR mode after grants 15 and 14: rst=1 for one cycle clears op_valid. With ip=16'hFFFF and rst released, the first grant is 15.
- N=5, RR, ip=5'b10001 held, ready=1:
  - grants are 4, 0, 4;
  - op never exceeds 4 and ptr wraps correctly.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants and helpers for the priority-encoder family.
package enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Stand-in for $clog2 on tools that lack it.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/prio_encoder_rr_prio_pick.sv
// Combinational picker: first set bit searching down from ptr, wrapping to N-1.
module prio_pick
  import enc_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any,
  output logic         multi
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   hi;
  logic [W:0]     sum;

  // rot[k] = req[(k+ptr+1) mod N], so rot[N-1] is req[ptr] and the
  // highest set rot bit is the first hit of the downward search.
  always_comb begin
    dbl = {req, req} >> ({1'b0, ptr} + 1'b1);
    rot = dbl[N-1:0];
  end

  always_comb begin
    hi = '0;
    for (int k = 0; k < N; k++)
      if (rot[k]) hi = W'(k);
  end

  always_comb begin
    sum    = {1'b0, hi} + {1'b0, ptr} + (W+1)'(1);
    winner = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    any    = |req;
    multi  = $countones(req) > 1;
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// N-to-log2(N) priority encoder, fixed or round-robin, with a registered valid/ready output.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter  int N    = 16,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] ip,
  input  logic         op_ready,
  output logic         op_valid,
  output logic [W-1:0] op,
  output logic [N-1:0] op_onehot,
  output logic         multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] eff_ptr;
  logic [W-1:0] win;
  logic         any;
  logic         win_multi;
  logic         cap;

  // Fixed mode is round-robin with the pointer pinned at the top index.
  assign eff_ptr = (MODE == MODE_RR) ? ptr : W'(N-1);

  prio_pick #(.N(N)) u_pick (
    .req    (ip),
    .ptr    (eff_ptr),
    .winner (win),
    .any    (any),
    .multi  (win_multi)
  );

  assign cap = en & any & (~op_valid | op_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid  <= 1'b0;
      op        <= '0;
      op_onehot <= '0;
      multi     <= 1'b0;
      ptr       <= W'(N-1);
    end else if (cap) begin
      op_valid  <= 1'b1;
      op        <= win;
      op_onehot <= N'(1) << win;
      multi     <= win_multi;
      if (MODE == MODE_RR)
        ptr <= (win == '0) ? W'(N-1) : win - 1'b1;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule
